// File: rtl/uart_cmd_parser.sv
// UART command parser: turns 5-byte frames (HEADER, ADDR, DH, DL, CHK)
// into register writes.
// Each frame gets an optional ACK (5A) or NAK (EE) response byte.
// If the gap between two bytes inside a frame is too long, the partial
// frame is abandoned.
//
// state    | meaning
// ---------+-------------------------------------------------
// IDLE     | hunting for HEADER, other bytes dropped silently
// GET_ADDR | header seen, waiting for register address
// GET_DH   | waiting for data high byte
// GET_DL   | waiting for data low byte
// GET_CHK  | waiting for checksum byte, frame resolves here
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [31:0] TIMEOUT_CYC = 32'd500000,
  parameter logic        ACK_EN      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  output logic        reg_wr,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_req,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DH   = 3'd2,
    GET_DL   = 3'd3,
    GET_CHK  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [7:0]  addr_q, dh_q, dl_q;
  logic [7:0]  sum_exp;
  logic        chk_ok, chk_bad, tmo;
  logic        resp_go;
  logic [7:0]  resp_byte;

  assign sum_exp = addr_q + dh_q + dl_q;

  // Frame sequencing and inter-byte timeout; a byte always wins over timeout.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    chk_ok    = 1'b0;
    chk_bad   = 1'b0;
    tmo       = 1'b0;
    if (rx_valid) begin
      cnt_nxt = '0;
      case (state)
        IDLE:     if (rx_data == HEADER) state_nxt = GET_ADDR;
        GET_ADDR: state_nxt = GET_DH;
        GET_DH:   state_nxt = GET_DL;
        GET_DL:   state_nxt = GET_CHK;
        GET_CHK: begin
          state_nxt = IDLE;
          if (rx_data == sum_exp) chk_ok = 1'b1;
          else                    chk_bad = 1'b1;
        end
        default:  state_nxt = IDLE;
      endcase
    end else if (state != IDLE) begin
      if (cnt == TIMEOUT_CYC - 32'd1) begin
        tmo       = 1'b1;
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + 32'd1;
      end
    end
  end

  // State register and inter-byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Capture payload bytes as they arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      dh_q   <= '0;
      dl_q   <= '0;
    end else if (rx_valid) begin
      case (state)
        GET_ADDR: addr_q <= rx_data;
        GET_DH:   dh_q   <= rx_data;
        GET_DL:   dl_q   <= rx_data;
        default:  ;
      endcase
    end
  end

  // Register write port, error pulse and response staging.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      frame_err <= 1'b0;
      resp_go   <= 1'b0;
      resp_byte <= '0;
    end else begin
      reg_wr    <= chk_ok;
      frame_err <= chk_bad | tmo;
      resp_go   <= ACK_EN & (chk_ok | chk_bad);
      if (chk_ok) begin
        reg_addr  <= addr_q;
        reg_wdata <= {dh_q, dl_q};
      end
      if (chk_ok | chk_bad) resp_byte <= chk_ok ? 8'h5A : 8'hEE;
    end
  end

  // Single-entry response slot; a response arriving while the slot is full is
  // dropped unless the slot is being emptied in that same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (resp_go) begin
      if (!tx_valid || tx_req) begin
        tx_valid <= 1'b1;
        tx_data  <= resp_byte;
      end
    end else if (tx_valid && tx_req) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser.
// A byte-level frame model predicts every output on every cycle.
// Directed frames with literal expectations run first, then randomized traffic.
module tb_uart_cmd_parser;
  localparam logic [7:0] HDR = 8'hA5;
  localparam int         TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_req = 1'b0;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        frame_err;

  uart_cmd_parser #(.HEADER(HDR), .TIMEOUT_CYC(32'(TMO)), .ACK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_req(tx_req),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs = 0;
  logic rand_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model state: the bytes of the frame collected so far.
  logic [7:0]  m_frame[$];
  int          m_gap = 0;
  logic        m_reg_wr = 0, m_frame_err = 0, m_tx_valid = 0;
  logic [7:0]  m_addr = 0, m_tx_data = 0;
  logic [15:0] m_wdata = 0;
  logic        m_resp_new = 0;
  logic [7:0]  m_resp_val = 0;

  task automatic model_step();
    logic       resp_prev;
    logic [7:0] resp_prev_val;
    logic [7:0] s;
    if (!rst_n) begin
      m_frame.delete();
      m_gap = 0; m_reg_wr = 0; m_frame_err = 0; m_tx_valid = 0;
      m_addr = 0; m_wdata = 0; m_tx_data = 0; m_resp_new = 0; m_resp_val = 0;
      return;
    end
    resp_prev = m_resp_new;
    resp_prev_val = m_resp_val;
    m_reg_wr = 0; m_frame_err = 0; m_resp_new = 0;
    // Responses reach the slot one cycle after the frame verdict.
    // The slot is free if it is empty or is being taken this very cycle.
    if (m_tx_valid && tx_req) m_tx_valid = 0;
    if (resp_prev && !m_tx_valid) begin
      m_tx_valid = 1;
      m_tx_data = resp_prev_val;
    end
    if (rx_valid) begin
      m_gap = 0;
      if (m_frame.size() == 0) begin
        if (rx_data == HDR) m_frame.push_back(rx_data);
      end else begin
        m_frame.push_back(rx_data);
        if (m_frame.size() == 5) begin
          s = m_frame[1] + m_frame[2] + m_frame[3];
          if (s == m_frame[4]) begin
            m_reg_wr = 1;
            m_addr = m_frame[1];
            m_wdata = {m_frame[2], m_frame[3]};
            m_resp_val = 8'h5A;
          end else begin
            m_frame_err = 1;
            m_resp_val = 8'hEE;
          end
          m_resp_new = 1;
          m_frame.delete();
        end
      end
    end else if (m_frame.size() > 0) begin
      m_gap++;
      if (m_gap == TMO) begin
        m_frame.delete();
        m_gap = 0;
        m_frame_err = 1;
      end
    end
  endtask

  // Model advance at each edge, full compare just after it.
  initial forever begin
    @(posedge clk);
    model_step();
    #1;
    check("reg_wr", 32'(reg_wr), 32'(m_reg_wr));
    check("frame_err", 32'(frame_err), 32'(m_frame_err));
    check("reg_addr", 32'(reg_addr), 32'(m_addr));
    check("reg_wdata", 32'(reg_wdata), 32'(m_wdata));
    check("tx_valid", 32'(tx_valid), 32'(m_tx_valid));
    if (m_tx_valid) check("tx_data", 32'(tx_data), 32'(m_tx_data));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_tx) tx_req = ($urandom_range(0, 2) == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send5(input logic [7:0] b0, b1, b2, b3, b4);
    send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3); send_byte(b4);
  endtask

  task automatic take_tx();
    tx_req = 1'b1;
    cyc();
    tx_req = 1'b0;
  endtask

  function automatic int pick_gap();
    int r;
    r = $urandom_range(0, 15);
    if (r < 10) return 0;
    if (r < 14) return $urandom_range(1, 4);
    if (r == 14) return TMO - 1;
    return TMO;
  endfunction

  initial begin
    logic [7:0] a, dh, dl, ck, nb;
    int kind, nbytes;
    idle(3);
    #1 rst_n = 1'b1;
    check("rst_reg_addr", 32'(reg_addr), 32'h0);
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    idle(2);

    // Good frame, ACK held until taken.
    send5(HDR, 8'h10, 8'h12, 8'h34, 8'h56);
    check("good_wr", 32'(reg_wr), 32'h1);
    check("good_addr", 32'(reg_addr), 32'h10);
    check("good_wdata", 32'(reg_wdata), 32'h1234);
    cyc();
    check("good_wr_once", 32'(reg_wr), 32'h0);
    check("ack_valid", 32'(tx_valid), 32'h1);
    check("ack_data", 32'(tx_data), 32'h5A);
    idle(4);
    check("ack_held", 32'(tx_data), 32'h5A);
    take_tx();
    check("ack_taken", 32'(tx_valid), 32'h0);

    // Bad checksum: NAK, no write.
    send5(HDR, 8'h10, 8'h12, 8'h34, 8'h00);
    check("bad_err", 32'(frame_err), 32'h1);
    check("bad_nowr", 32'(reg_wr), 32'h0);
    cyc();
    check("bad_err_once", 32'(frame_err), 32'h0);
    check("nak_data", 32'(tx_data), 32'hEE);
    take_tx();

    // Leading garbage, checksum wraps to 00.
    send_byte(8'h00); send_byte(8'hFF);
    send5(HDR, 8'h01, 8'h00, 8'hFF, 8'h00);
    check("garb_wr", 32'(reg_wr), 32'h1);
    check("garb_addr", 32'(reg_addr), 32'h01);
    check("garb_wdata", 32'(reg_wdata), 32'h00FF);
    cyc();
    take_tx();

    // Inter-byte timeout, then recovery.
    send_byte(HDR); send_byte(8'h20);
    idle(TMO - 1);
    check("tmo_early", 32'(frame_err), 32'h0);
    cyc();
    check("tmo_err", 32'(frame_err), 32'h1);
    idle(3);
    check("tmo_no_tx", 32'(tx_valid), 32'h0);
    send5(HDR, 8'h33, 8'h01, 8'h02, 8'h36);
    check("tmo_recover", 32'(reg_addr), 32'h33);
    cyc();
    take_tx();

    // Back-to-back frames with the response slot blocked.
    send5(HDR, 8'h40, 8'h00, 8'h01, 8'h41);
    send5(HDR, 8'h41, 8'h00, 8'h02, 8'h43);
    check("b2b_wr2", 32'(reg_wr), 32'h1);
    check("b2b_addr2", 32'(reg_addr), 32'h41);
    idle(3);
    check("b2b_first_ack", 32'(tx_data), 32'h5A);
    take_tx();
    idle(3);
    check("b2b_dropped", 32'(tx_valid), 32'h0);

    // Reset in the middle of a frame.
    send_byte(HDR); send_byte(8'h50); send_byte(8'h11);
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", 32'(reg_addr), 32'h0);
    check("async_rst_wdata", 32'(reg_wdata), 32'h0);
    idle(2);
    rst_n = 1'b1;
    send_byte(8'h22); send_byte(8'h83);
    idle(3);
    check("rst_partial_dropped", 32'(tx_valid), 32'h0);
    send5(HDR, 8'h50, 8'h11, 8'h22, 8'h83);
    check("post_rst_wdata", 32'(reg_wdata), 32'h1122);
    cyc();
    take_tx();

    // Randomized traffic.
    rand_tx = 1'b1;
    for (int f = 0; f < 300; f++) begin
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        nb = 8'($urandom_range(0, 255));
        if (nb == HDR) nb = 8'h00;
        send_byte(nb);
      end else begin
        a = 8'($urandom_range(0, 255));
        dh = 8'($urandom_range(0, 255));
        dl = 8'(kind == 4 ? HDR : $urandom_range(0, 255));
        ck = a + dh + dl;
        if (kind == 2) ck = ck ^ 8'(1 << $urandom_range(0, 7));
        nbytes = (kind == 3) ? $urandom_range(1, 4) : 5;
        for (int i = 0; i < nbytes; i++) begin
          case (i)
            0: send_byte(HDR);
            1: send_byte(a);
            2: send_byte(dh);
            3: send_byte(dl);
            default: send_byte(ck);
          endcase
          if (i < nbytes - 1) idle(pick_gap());
        end
        if (kind == 3) idle(TMO + 1);
      end
      idle($urandom_range(0, 2));
    end
    rand_tx = 1'b0;
    tx_req = 1'b0;
    idle(5);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
